// File: rtl/flash_ctrl_top_specific_pkg.sv
// Flash controller types shared across the controller: partition select and program type.
package flash_ctrl_top_specific_pkg;

    typedef enum logic [1:0] {
        FlashPartData = 2'd0,
        FlashPartInfo = 2'd1
    } flash_part_e;

    typedef enum logic [1:0] {
        FlashProgNormal = 2'd0,
        FlashProgRepair = 2'd1
    } flash_prog_e;

endpackage

// File: rtl/flash_prog_resp.sv
// Flash program responder: validates a program request, models the program busy time,
// then writes the word into a Data+Info register array; separate registered readback port.
module flash_prog_resp
    import flash_ctrl_top_specific_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DATA_WORDS  = 16,
    parameter int INFO_WORDS  = 4,
    parameter int PROG_CYCLES = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_i,
    output logic                          req_ready_o,
    input  logic [$clog2(DATA_WORDS)-1:0] addr_i,
    input  logic [1:0]                    part_i,
    input  logic [1:0]                    prog_type_i,
    input  logic [DATA_W-1:0]             data_i,
    output logic                          done_o,
    output logic                          err_o,
    input  logic [$clog2(DATA_WORDS)-1:0] rd_addr_i,
    input  logic [1:0]                    rd_part_i,
    output logic [DATA_W-1:0]             rd_data_o
);

    localparam int AW    = $clog2(DATA_WORDS);
    localparam int TOTAL = DATA_WORDS + INFO_WORDS;
    localparam int IW    = $clog2(TOTAL);
    localparam int CW    = $clog2(PROG_CYCLES + 1);

    typedef logic [1:0] state_t;
    localparam state_t StIdle  = 2'd0;
    localparam state_t StCheck = 2'd1;
    localparam state_t StProg  = 2'd2;
    localparam state_t StResp  = 2'd3;

    state_t            stateQ;
    state_t            nextState;
    logic [CW-1:0]     cntQ;
    logic [AW-1:0]     addrQ;
    logic [1:0]        partQ;
    logic [1:0]        typeQ;
    logic [DATA_W-1:0] dataQ;
    logic [DATA_W-1:0] wdataQ;
    logic              doneQ;
    logic              errQ;
    logic              readyQ;
    logic [DATA_W-1:0] rdDataQ;
    logic [DATA_W-1:0] mem [TOTAL];

    logic [IW:0]       tgt;
    logic [IW:0]       rdTgt;
    logic [DATA_W-1:0] oldWord;
    logic [DATA_W-1:0] newWord;
    logic              chkErr;

    // Info words live above the Data words; MSB of the result flags a valid location.
    function automatic logic [IW:0] wordIndex(input logic [1:0] part, input logic [AW-1:0] addr);
        logic [IW:0] res;
        res = '0;
        if (part == FlashPartData && 32'(addr) < DATA_WORDS) begin
            res = {1'b1, IW'(addr)};
        end else if (part == FlashPartInfo && 32'(addr) < INFO_WORDS) begin
            res = {1'b1, IW'(DATA_WORDS + 32'(addr))};
        end else begin
            res = '0;
        end
        return res;
    endfunction

    // Request validation, program data and next-state decode
    always_comb begin
        tgt     = wordIndex(partQ, addrQ);
        rdTgt   = wordIndex(rd_part_i, rd_addr_i);
        oldWord = tgt[IW] ? mem[tgt[IW-1:0]] : '1;
        chkErr  = !tgt[IW]
               || (typeQ != FlashProgNormal && typeQ != FlashProgRepair)
               || (typeQ == FlashProgNormal && (dataQ & ~oldWord) != '0);
        newWord = (typeQ == FlashProgRepair) ? dataQ : (oldWord & dataQ);
        nextState = stateQ;
        case (stateQ)
            StIdle:  nextState = req_i ? StCheck : StIdle;
            StCheck: nextState = chkErr ? StResp : StProg;
            StProg:  nextState = (cntQ == '0) ? StResp : StProg;
            StResp:  nextState = StIdle;
            default: nextState = StIdle;
        endcase
    end

    // FSM state, request capture, busy counter and registered handshake/response outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            addrQ  <= '0;
            partQ  <= 2'd0;
            typeQ  <= 2'd0;
            dataQ  <= '0;
            wdataQ <= '0;
            doneQ  <= 1'b0;
            errQ   <= 1'b0;
            readyQ <= 1'b1;
        end else begin
            stateQ <= nextState;
            doneQ  <= (nextState == StResp);
            errQ   <= (stateQ == StCheck) && chkErr;
            readyQ <= (nextState == StIdle);
            case (stateQ)
                StIdle: begin
                    if (req_i) begin
                        addrQ <= addr_i;
                        partQ <= part_i;
                        typeQ <= prog_type_i;
                        dataQ <= data_i;
                    end
                end
                StCheck: begin
                    wdataQ <= newWord;
                    if (!chkErr) begin
                        cntQ <= CW'(PROG_CYCLES - 1);
                    end
                end
                StProg: begin
                    if (cntQ != '0) begin
                        cntQ <= cntQ - CW'(1);
                    end
                end
                default: begin
                    cntQ <= cntQ;
                end
            endcase
        end
    end

    // Storage array: erased on reset, single write on the last busy cycle; registered readback
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < TOTAL; i++) begin
                mem[i] <= '1;
            end
            rdDataQ <= '1;
        end else begin
            if (stateQ == StProg && cntQ == '0) begin
                mem[tgt[IW-1:0]] <= wdataQ;
            end
            rdDataQ <= rdTgt[IW] ? mem[rdTgt[IW-1:0]] : '1;
        end
    end

    assign req_ready_o = readyQ;
    assign done_o      = doneQ;
    assign err_o       = errQ;
    assign rd_data_o   = rdDataQ;

endmodule
